// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// parity type constants and the default oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_CHECK  = 3'd5
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Oversampling ratio assumed before the first frame latches a real one
  localparam int DEFAULT_PRESCALE = 8;

  // Parity bit the transmitter should have sent, given the XOR of the data bits
  function automatic logic expected_parity(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler: captures the synchronized line on three consecutive
// oversample ticks around the bit centre and resolves them by 2-of-3 vote,
// so a single-cycle glitch near mid-bit cannot flip the received bit.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] p,
  output logic                  sampled_bit,
  output logic                  sample_done
);

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            taps;

  assign half = p >> 1;

  // Capture the line one tick before, at, and one tick after the bit centre
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= 3'b111;
    end else begin
      if (edge_cnt == half - PRESCALE_W'(1)) taps[0] <= rx_s;
      if (edge_cnt == half)                  taps[1] <= rx_s;
      if (edge_cnt == half + PRESCALE_W'(1)) taps[2] <= rx_s;
    end
  end

  assign sampled_bit = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
  assign sample_done = (edge_cnt == half + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, tracks bit timing with an
// oversample counter, deserializes LSB-first data, checks parity and stop,
// and reports each frame with single-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_ENABLE,
  input  logic                  PAR_TYP,
  output logic [WIDTH-1:0]      P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int              BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  rx_state_t             state;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [PRESCALE_W-1:0] p_in;
  logic [PRESCALE_W-1:0] p_reg;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [WIDTH-1:0]      data_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  par_bad;
  logic                  stp_bad;
  logic                  bit_end;
  logic                  sampled_bit;
  logic                  sample_done;

  // Odd prescale values are rounded down so the bit centre is well defined
  assign p_in    = PRESCALE & ~PRESCALE_W'(1);
  assign rx_s    = sync_q[1];
  assign bit_end = (edge_cnt == p_reg - PRESCALE_W'(1));
  assign stp_bad = ~sampled_bit;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_s        (rx_s),
    .edge_cnt    (edge_cnt),
    .p           (p_reg),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  // Frame FSM with counters, deserializer, checks and registered result pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      p_reg       <= PRESCALE_W'(DEFAULT_PRESCALE);
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      par_bad     <= 1'b0;
      P_DATA      <= '0;
      DATA_VALID  <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      case (state)
        ST_IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            state       <= ST_START;
            p_reg       <= p_in;
            par_en_reg  <= PAR_ENABLE;
            par_typ_reg <= PAR_TYP;
            par_bad     <= 1'b0;
          end
        end
        ST_START: begin
          if (sample_done && sampled_bit) begin
            state    <= ST_IDLE;
            edge_cnt <= '0;
          end else if (bit_end) begin
            state    <= ST_DATA;
            edge_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
          end
        end
        ST_DATA: begin
          if (sample_done) begin
            data_reg <= {sampled_bit, data_reg[WIDTH-1:1]};
          end
          if (bit_end) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_reg ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
          end
        end
        ST_PARITY: begin
          if (sample_done && (sampled_bit != expected_parity(^data_reg, par_typ_reg))) begin
            par_bad <= 1'b1;
          end
          if (bit_end) begin
            edge_cnt <= '0;
            state    <= ST_STOP;
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
          end
        end
        ST_STOP: begin
          if (sample_done) begin
            state    <= ST_CHECK;
            edge_cnt <= '0;
            PAR_ERR  <= par_bad;
            STP_ERR  <= stp_bad;
            if (!par_bad && !stp_bad) begin
              DATA_VALID <= 1'b1;
              P_DATA     <= data_reg;
            end
          end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
          end
        end
        ST_CHECK: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            state       <= ST_START;
            p_reg       <= p_in;
            par_en_reg  <= PAR_ENABLE;
            par_typ_reg <= PAR_TYP;
            par_bad     <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives hand-built serial frames and checks
// the result pulses and received words against hand-computed values.
module tb_uart_rx;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       rx_in      = 1'b1;
  logic [5:0] prescale   = 6'd8;
  logic       par_enable = 1'b0;
  logic       par_typ    = 1'b0;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  int         dv_count      = 0;
  int         pe_count      = 0;
  int         se_count      = 0;
  int         prev_dv_cycle = 0;
  int         last_dv_cycle = 0;
  logic [7:0] first_data    = 8'h00;
  logic [7:0] last_data     = 8'h00;
  logic [7:0] abort_word    = 8'hF0;

  uart_rx #(
    .WIDTH      (8),
    .PRESCALE_W (6)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx_in),
    .PRESCALE   (prescale),
    .PAR_ENABLE (par_enable),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err)
  );

  // Free-running oversampling clock
  always #5 clk = ~clk;

  // Cycle counter used to time the spacing between result pulses
  always @(posedge clk) cycle++;

  // Monitor: counts high cycles of each result output while out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        if (dv_count == 0) first_data = p_data;
        last_data     = p_data;
        prev_dv_cycle = last_dv_cycle;
        last_dv_cycle = cycle;
        dv_count++;
      end
      if (par_err) pe_count++;
      if (stp_err) se_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMon();
    dv_count = 0;
    pe_count = 0;
    se_count = 0;
  endtask

  task automatic driveBit(input logic v, input int p);
    rx_in = v;
    repeat (p) @(negedge clk);
  endtask

  task automatic idleWait(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // One frame: start, 8 data bits LSB first, optional parity, stop
  task automatic applyStimulus(input logic [7:0] d, input int p, input logic with_par,
                               input logic par_bit, input logic stop_bit);
    driveBit(1'b0, p);
    for (int i = 0; i < 8; i++) driveBit(d[i], p);
    if (with_par) driveBit(par_bit, p);
    driveBit(stop_bit, p);
  endtask

  task automatic checkCounts(input string tag, input int exp_dv, input int exp_pe, input int exp_se);
    checkOutput({tag, "_dv_pulses"}, dv_count, exp_dv);
    checkOutput({tag, "_par_err_pulses"}, pe_count, exp_pe);
    checkOutput({tag, "_stp_err_pulses"}, se_count, exp_se);
  endtask

  // Directed sequence
  initial begin
    int spacing;
    $display("[TB] uart_rx directed test start");
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_p_data", p_data, 8'h00);
    checkOutput("reset_data_valid", data_valid, 1'b0);
    checkOutput("reset_par_err", par_err, 1'b0);
    checkOutput("reset_stp_err", stp_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    idleWait(32);

    // 1: PRESCALE 8, no parity, 0xA5
    $display("[TB] case 1: 0xA5 at prescale 8");
    prescale = 6'd8; par_enable = 1'b0; par_typ = 1'b0;
    clearMon();
    applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    idleWait(16);
    checkCounts("c1", 1, 0, 0);
    checkOutput("c1_word", last_data, 8'hA5);
    checkOutput("c1_p_data_hold", p_data, 8'hA5);

    // 2: PRESCALE 16, even parity, 0x3C has four ones so parity should be 0; send 1
    $display("[TB] case 2: 0x3C with wrong even parity");
    prescale = 6'd16; par_enable = 1'b1; par_typ = 1'b0;
    clearMon();
    applyStimulus(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    idleWait(32);
    checkCounts("c2", 0, 1, 0);
    checkOutput("c2_p_data_kept", p_data, 8'hA5);

    // 3: PRESCALE 32, 0x81 with stop bit 0, then a clean 0x7E
    $display("[TB] case 3: stop error then 0x7E at prescale 32");
    prescale = 6'd32; par_enable = 1'b0;
    clearMon();
    applyStimulus(8'h81, 32, 1'b0, 1'b0, 1'b0);
    idleWait(64);
    checkCounts("c3a", 0, 0, 1);
    checkOutput("c3a_p_data_kept", p_data, 8'hA5);
    clearMon();
    applyStimulus(8'h7E, 32, 1'b0, 1'b0, 1'b1);
    idleWait(64);
    checkCounts("c3b", 1, 0, 0);
    checkOutput("c3b_word", last_data, 8'h7E);

    // 4: two-cycle low glitch while idle, then 0x55
    $display("[TB] case 4: start glitch then 0x55 at prescale 16");
    prescale = 6'd16;
    clearMon();
    driveBit(1'b0, 2);
    idleWait(48);
    checkCounts("c4a", 0, 0, 0);
    checkOutput("c4a_p_data_kept", p_data, 8'h7E);
    clearMon();
    applyStimulus(8'h55, 16, 1'b0, 1'b0, 1'b1);
    idleWait(32);
    checkCounts("c4b", 1, 0, 0);
    checkOutput("c4b_word", last_data, 8'h55);

    // 5: back-to-back 0x12 (parity 1) and 0x34 (parity 0), odd parity, 11-bit frames of 8 cycles
    $display("[TB] case 5: back-to-back 0x12 0x34 odd parity");
    prescale = 6'd8; par_enable = 1'b1; par_typ = 1'b1;
    clearMon();
    applyStimulus(8'h12, 8, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h34, 8, 1'b1, 1'b0, 1'b1);
    idleWait(16);
    checkCounts("c5", 2, 0, 0);
    checkOutput("c5_first_word", first_data, 8'h12);
    checkOutput("c5_second_word", last_data, 8'h34);
    spacing = last_dv_cycle - prev_dv_cycle;
    checkOutput("c5_pulse_spacing", (spacing >= 87 && spacing <= 89) ? 32'd88 : spacing, 32'd88);

    // 6: reset during data bit 4, then 0xC3
    $display("[TB] case 6: reset mid-frame then 0xC3");
    par_enable = 1'b0; par_typ = 1'b0;
    clearMon();
    driveBit(1'b0, 8);
    for (int i = 0; i < 4; i++) driveBit(abort_word[i], 8);
    driveBit(abort_word[4], 4);
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("c6_reset_p_data", p_data, 8'h00);
    checkOutput("c6_reset_data_valid", data_valid, 1'b0);
    checkOutput("c6_reset_par_err", par_err, 1'b0);
    checkOutput("c6_reset_stp_err", stp_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    clearMon();
    idleWait(16);
    applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    idleWait(16);
    checkCounts("c6", 1, 0, 0);
    checkOutput("c6_word", last_data, 8'hC3);
    checkOutput("c6_p_data_hold", p_data, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
